// File: rtl/score_display_pkg.sv
// Shared constants, segment code table and engine state type for the
// multi-digit scoreboard display.
package score_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} conv_state_e;

  // Active-low segment pattern for one BCD digit; non-decimal nibbles are blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] code;
    case (nibble)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Decimal digits needed for a w-bit binary value: ceil(w * log10(2)).
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle,
// followed by a single LOAD cycle in which the result is presented.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int BCD_DIGITS = bcd_digits(SCORE_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      score,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int IW = $clog2(SCORE_W + 1);

  conv_state_e             state_q, state_d;
  logic [SCORE_W-1:0]      bin_q, bin_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
  logic [IW-1:0]           iter_q, iter_d;

  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = score;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d  = {bcd_adj[4*BCD_DIGITS-2:0], bin_q[SCORE_W-1]};
        bin_d  = bin_q << 1;
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(SCORE_W - 1)) state_d = LOAD;
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == LOAD);
  assign bcd  = bcd_q;

endmodule

// File: rtl/score_display_multi.sv
// Scoreboard display: change-triggered BCD conversion of the score, then
// registered 7-segment drive with leading-zero blanking, overflow dash and blink.
module score_display_multi
  import score_display_pkg::*;
#(
  parameter int SCORE_W   = 8,
  parameter int DIGITS    = 3,
  parameter int BLINK_DIV = 25,
  parameter int LZ_BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score,
  input  logic                  blink_en,
  output logic [DIGITS*7-1:0]   seg,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int BCD_DIGITS = bcd_digits(SCORE_W);
  localparam int PAD_DIGITS = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
  localparam int CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic                    pending_q;
  logic [SCORE_W-1:0]      last_score_q;
  logic [4*DIGITS-1:0]     digit_q;
  logic                    overflow_q;
  logic                    done_q;
  logic [CW-1:0]           blink_cnt_q;
  logic                    blink_off_q;
  logic [DIGITS*7-1:0]     seg_q, seg_d;

  logic                    start;
  logic                    eng_busy;
  logic                    eng_done;
  logic [4*BCD_DIGITS-1:0] eng_bcd;
  logic [4*PAD_DIGITS-1:0] bcd_pad;
  logic                    upper_nz;

  assign start = pending_q | (score != last_score_q);

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .score (score),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_comb begin
    bcd_pad                   = '0;
    bcd_pad[4*BCD_DIGITS-1:0] = eng_bcd;
  end

  // Any nonzero nibble above the displayed digits means the score does not fit.
  assign upper_nz = |(bcd_pad >> (4 * DIGITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 1'b1;
      last_score_q <= '0;
      digit_q      <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      seg_q        <= {DIGITS{SEG_BLANK}};
    end else begin
      done_q <= eng_done;
      if (!eng_busy && start) begin
        last_score_q <= score;
        pending_q    <= 1'b0;
      end
      if (eng_done) begin
        digit_q    <= bcd_pad[4*DIGITS-1:0];
        overflow_q <= upper_nz;
      end
      seg_q <= seg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !blink_en) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + CW'(1);
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
    logic [3:0] nib;
    logic       nz_from;
    logic       lz;
    assign nib     = digit_q[4*gi +: 4];
    // Digit is a leading zero when it and every higher digit are zero.
    assign nz_from = |digit_q[4*DIGITS-1:4*gi];
    assign lz      = (LZ_BLANK != 0) && (gi > 0) && !nz_from;
    assign seg_d[7*gi +: 7] = blink_off_q ? SEG_BLANK :
                              overflow_q  ? SEG_DASH  :
                              lz          ? SEG_BLANK : seg_decode(nib);
  end

  assign seg      = seg_q;
  assign busy     = eng_busy;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_score_display_multi.sv
// Directed bench for score_display_multi: a 3-digit instance (blink period 4)
// and a 2-digit instance for the overflow display.
module tb_score_display_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  score;
  logic [7:0]  score2;
  logic        blink_en;
  logic [20:0] seg;
  logic [13:0] seg2;
  logic        busy, done, overflow;
  logic        busy2, done2, overflow2;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] B = 7'h7F;

  always #5 clk = ~clk;

  score_display_multi #(.SCORE_W(8), .DIGITS(3), .BLINK_DIV(4), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .score(score), .blink_en(blink_en),
    .seg(seg), .busy(busy), .done(done), .overflow(overflow)
  );

  score_display_multi #(.SCORE_W(8), .DIGITS(2), .BLINK_DIV(4), .LZ_BLANK(1)) dut2 (
    .clk(clk), .rst(rst), .score(score2), .blink_en(blink_en),
    .seg(seg2), .busy(busy2), .done(done2), .overflow(overflow2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int done_cnt = 0;
    int done_at  = -1;
    rst = 1'b1; score = 8'd0; score2 = 8'd0; blink_en = 1'b0;
    tick(); tick();
    checks++; if (seg !== {B, B, B}) begin errors++; $display("FAIL reset_seg: got %h expected %h", seg, {B, B, B}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL reset_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_at != 9) begin errors++; $display("FAIL reset_done_time: got %0d expected 9", done_at); end
    checks++; if (seg !== {B, B, 7'h40}) begin errors++; $display("FAIL reset_zero_seg: got %h expected %h", seg, {B, B, 7'h40}); end
    checks++; if (seg2 !== {B, 7'h40}) begin errors++; $display("FAIL reset_zero_seg2: got %h expected %h", seg2, {B, 7'h40}); end
    $display("reset: seg=%h done_count=%0d done_at=%0d", seg, done_cnt, done_at);
  endtask

  task automatic test_255();
    int busy_cnt = 0;
    int done_cnt = 0;
    score = 8'd255;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (k == 9) begin
        checks++; if (seg !== {B, B, 7'h40}) begin errors++; $display("FAIL latency_early: got %h expected %h", seg, {B, B, 7'h40}); end
      end
      if (k == 10) begin
        checks++; if (seg !== {7'h24, 7'h12, 7'h12}) begin errors++; $display("FAIL latency_255: got %h expected %h", seg, {7'h24, 7'h12, 7'h12}); end
      end
    end
    checks++; if (busy_cnt != 9) begin errors++; $display("FAIL busy_len: got %0d expected 9", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_255: got %0d expected 1", done_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_255: got %b expected 0", overflow); end
    $display("score 255: seg=%h busy_cycles=%0d", seg, busy_cnt);
  endtask

  task automatic test_overflow();
    score2 = 8'd137;
    for (int k = 0; k < 15; k++) tick();
    checks++; if (overflow2 !== 1'b1) begin errors++; $display("FAIL ovf_137_flag: got %b expected 1", overflow2); end
    checks++; if (seg2 !== {7'h3F, 7'h3F}) begin errors++; $display("FAIL ovf_137_seg: got %h expected %h", seg2, {7'h3F, 7'h3F}); end
    $display("2-digit score 137: seg=%h overflow=%b", seg2, overflow2);
    score2 = 8'd42;
    for (int k = 0; k < 15; k++) tick();
    checks++; if (overflow2 !== 1'b0) begin errors++; $display("FAIL ovf_42_flag: got %b expected 0", overflow2); end
    checks++; if (seg2 !== {7'h19, 7'h24}) begin errors++; $display("FAIL ovf_42_seg: got %h expected %h", seg2, {7'h19, 7'h24}); end
    $display("2-digit score 42: seg=%h overflow=%b", seg2, overflow2);
  endtask

  task automatic test_vectors();
    logic [7:0]  vin  [4] = '{8'd5, 8'd10, 8'd100, 8'd250};
    logic [20:0] vexp [4] = '{{B, B, 7'h12}, {B, 7'h79, 7'h40},
                              {7'h79, 7'h40, 7'h40}, {7'h24, 7'h12, 7'h40}};
    for (int v = 0; v < 4; v++) begin
      score = vin[v];
      for (int k = 0; k < 14; k++) tick();
      checks++; if (seg !== vexp[v]) begin errors++; $display("FAIL vector_%0d: got %h expected %h", vin[v], seg, vexp[v]); end
      $display("score %0d: seg=%h", vin[v], seg);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int first_k  = -1;
    logic [20:0] mid_seg = '0;
    score = 8'd17;
    for (int k = 0; k < 34; k++) begin
      tick();
      if (first_k >= 0 && k == first_k + 1) mid_seg = seg;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_k < 0) first_k = k;
      end
      if (k == 3) score = 8'd200;
    end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt); end
    checks++; if (mid_seg !== {B, 7'h79, 7'h78}) begin errors++; $display("FAIL b2b_mid_seg: got %h expected %h", mid_seg, {B, 7'h79, 7'h78}); end
    checks++; if (seg !== {7'h24, 7'h40, 7'h40}) begin errors++; $display("FAIL b2b_final_seg: got %h expected %h", seg, {7'h24, 7'h40, 7'h40}); end
    $display("17->200 mid-conversion: done_count=%0d final seg=%h", done_cnt, seg);
  endtask

  task automatic test_blink();
    logic [20:0] digits = {7'h24, 7'h40, 7'h40};
    logic [20:0] exp_seg;
    blink_en = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick();
      exp_seg = (((j / 4) % 2) == 0) ? digits : {B, B, B};
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL blink_%0d: got %h expected %h", j, seg, exp_seg); end
    end
    blink_en = 1'b0;
    tick();
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++; if (seg !== digits) begin errors++; $display("FAIL steady_%0d: got %h expected %h", j, seg, digits); end
    end
    $display("blink: 14 toggling cycles then 10 steady cycles, seg=%h", seg);
  endtask

  task automatic test_rst_mid_conv();
    int done_cnt = 0;
    score = 8'd99;
    for (int k = 0; k < 4; k++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    tick();
    checks++; if (seg !== {B, B, B}) begin errors++; $display("FAIL rstmid_seg: got %h expected %h", seg, {B, B, B}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done_count: got %0d expected 1", done_cnt); end
    checks++; if (seg !== {B, 7'h10, 7'h10}) begin errors++; $display("FAIL rstmid_final_seg: got %h expected %h", seg, {B, 7'h10, 7'h10}); end
    $display("reset during conversion of 99: final seg=%h", seg);
  endtask

  initial begin
    test_reset();
    test_255();
    test_overflow();
    test_vectors();
    test_back_to_back();
    test_blink();
    test_rst_mid_conv();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
